alu_imm_stage: RTL and testbench



---
 rtl/rv32i_pkg.sv | 35 +++
 rtl/alu_imm_stage_if.sv | 28 ++
 rtl/alu_imm.sv | 59 +++++
 rtl/alu_imm_stage.sv | 101 ++++++++++
 tb/tb_alu_imm_stage.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I OP-IMM decode constants, FSM state type and ALU result payload.
package rv32i_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned OPCODE_W  = 7;
  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned FUNCT7_W  = 7;

  localparam logic [OPCODE_W-1:0] OPCODE_OP_IMM = 7'b0010011;

  localparam logic [FUNCT3_W-1:0] F3_ADDI  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_SLLI  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_SLTI  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_SLTIU = 3'b011;
  localparam logic [FUNCT3_W-1:0] F3_XORI  = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_SRXI  = 3'b101;
  localparam logic [FUNCT3_W-1:0] F3_ORI   = 3'b110;
  localparam logic [FUNCT3_W-1:0] F3_ANDI  = 3'b111;

  localparam logic [FUNCT7_W-1:0] FUNCT7_ZERO = 7'b0000000;
  localparam logic [FUNCT7_W-1:0] FUNCT7_SRA  = 7'b0100000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            legal;
  } alu_out_t;

endpackage

// File: rtl/alu_imm_stage_if.sv
// Instruction handshake plus register-file read/write port of the OP-IMM stage.
interface alu_imm_stage_if;
  import rv32i_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [XLEN-1:0]         in_instr;
  logic [REG_AW-1:0]       rs1;
  logic [XLEN-1:0]         rs1_value;
  logic [REG_AW-1:0]       rd;
  logic [XLEN-1:0]         rd_value;
  logic                    we;
  logic                    done;
  logic                    illegal;

  // Producer / register-file side
  modport master (
    output in_valid, in_instr, rs1_value,
    input  in_ready, rs1, rd, rd_value, we, done, illegal
  );

  // Stage side
  modport slave (
    input  in_valid, in_instr, rs1_value,
    output in_ready, rs1, rd, rd_value, we, done, illegal
  );

endinterface

// File: rtl/alu_imm.sv
// Combinational RV32I OP-IMM decoder/ALU: (operand, instruction) -> {result, legal}.
module alu_imm
  import rv32i_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] instr_i,
  output alu_out_t        alu_c_o
);

  logic [XLEN-1:0]     imm;
  logic [4:0]          shamt;
  logic [FUNCT3_W-1:0] funct3;
  logic [FUNCT7_W-1:0] funct7;
  logic                opcode_ok;
  logic                f3_legal;
  logic [XLEN-1:0]     result;
  logic                unused_rd_bits;

  assign imm       = {{20{instr_i[31]}}, instr_i[31:20]};
  assign shamt     = instr_i[24:20];
  assign funct3    = instr_i[14:12];
  assign funct7    = instr_i[31:25];
  assign opcode_ok = (instr_i[6:0] == OPCODE_OP_IMM);

  // rd and rs1 fields belong to the stage, not the datapath
  assign unused_rd_bits = ^{instr_i[19:15], instr_i[11:7]};

  // Per-funct3 operation and shift-encoding legality
  always_comb begin
    result   = '0;
    f3_legal = 1'b1;
    case (funct3)
      F3_ADDI:  result = a_i + imm;
      F3_SLTI:  result = XLEN'($signed(a_i) < $signed(imm));
      F3_SLTIU: result = XLEN'(a_i < imm);
      F3_XORI:  result = a_i ^ imm;
      F3_ORI:   result = a_i | imm;
      F3_ANDI:  result = a_i & imm;
      F3_SLLI: begin
        result   = a_i << shamt;
        f3_legal = (funct7 == FUNCT7_ZERO);
      end
      F3_SRXI: begin
        if (funct7 == FUNCT7_ZERO) begin
          result = a_i >> shamt;
        end else if (funct7 == FUNCT7_SRA) begin
          result = XLEN'($signed(a_i) >>> shamt);
        end else begin
          f3_legal = 1'b0;
        end
      end
      default: f3_legal = 1'b0;
    endcase
  end

  assign alu_c_o.result = result;
  assign alu_c_o.legal  = opcode_ok & f3_legal;

endmodule

// File: rtl/alu_imm_stage.sv
// Three-cycle OP-IMM execute/write-back stage: accept, read rs1 and compute, write back.
module alu_imm_stage
  import rv32i_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  alu_imm_stage_if.slave     bus
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   rd_value_q, rd_value_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic              in_ready_q, in_ready_d;
  logic [XLEN-1:0]   operand_c;
  alu_out_t          alu_c;

  // x0 is not stored in the register file, so force a zero operand for it
  assign operand_c = (rs1_q == '0) ? '0 : bus.rs1_value;

  alu_imm u_alu (
    .a_i     (operand_c),
    .instr_i (instr_q),
    .alu_c_o (alu_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    rs1_d      = rs1_q;
    rd_d       = rd_q;
    rd_value_d = rd_value_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          instr_d = bus.in_instr;
          rs1_d   = bus.in_instr[19:15];
          state_d = EXEC;
        end
      end
      EXEC: begin
        rs1_d      = '0;
        rd_d       = instr_q[11:7];
        rd_value_d = alu_c.result;
        we_d       = alu_c.legal && (instr_q[11:7] != '0);
        done_d     = 1'b1;
        illegal_d  = ~alu_c.legal;
        state_d    = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // Registered datapath and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= '0;
      rs1_q      <= '0;
      rd_q       <= '0;
      rd_value_q <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      instr_q    <= instr_d;
      rs1_q      <= rs1_d;
      rd_q       <= rd_d;
      rd_value_q <= rd_value_d;
      we_q       <= we_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.rs1      = rs1_q;
  assign bus.rd       = rd_q;
  assign bus.rd_value = rd_value_q;
  assign bus.we       = we_q;
  assign bus.done     = done_q;
  assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_alu_imm_stage.sv
// Bench for alu_imm_stage: directed OP-IMM cases, handshake/reset corners, random instructions.
module tb_alu_imm_stage;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [31:0] regs [32];
  logic [31:0] gold [32];
  logic        poke_en;
  logic [4:0]  poke_addr;
  logic [31:0] poke_data;

  alu_imm_stage_if bus ();

  alu_imm_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational read, write at the clock edge
  assign bus.rs1_value = regs[bus.rs1];
  always @(posedge clk) begin
    if (poke_en)     regs[poke_addr] <= poke_data;
    else if (bus.we) regs[bus.rd]    <= bus.rd_value;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_reg(input int idx, input logic [31:0] val);
    poke_en   = 1'b1;
    poke_addr = 5'(idx);
    poke_data = val;
    tick();
    poke_en   = 1'b0;
    gold[idx] = val;
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm12, input int r1,
                                        input int f3, input int rdn);
    return {imm12, 5'(r1), 3'(f3), 5'(rdn), 7'h13};
  endfunction

  // Architectural reference: returns {legal, value}
  function automatic logic [32:0] ref_op(input logic [31:0] ins, input logic [31:0] a);
    logic [31:0] imm;
    logic [31:0] v;
    int          sh;
    int          f3;
    int          f7;
    bit          ok;
    imm = {{20{ins[31]}}, ins[31:20]};
    sh  = int'(ins[24:20]);
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    ok  = (ins[6:0] == 7'h13);
    v   = 32'h0;
    case (f3)
      0: v = 32'((64'(a) + 64'(imm)) % 64'h1_0000_0000);
      1: begin v = a << sh; ok = ok && (f7 == 0); end
      2: v = (int'(a) < int'(imm)) ? 32'd1 : 32'd0;
      3: v = ({1'b0, a} < {1'b0, imm}) ? 32'd1 : 32'd0;
      4: v = a ^ imm;
      5: begin
        v = a >> sh;
        if (f7 == 32 && a[31] && sh > 0) v = v | ~(32'hFFFF_FFFF >> sh);
        ok = ok && (f7 == 0 || f7 == 32);
      end
      6: v = a | imm;
      default: v = a & imm;
    endcase
    return {ok, v};
  endfunction

  // Checks the write-back cycle of ins and retires it into the golden state
  task automatic wb_check(input logic [31:0] ins);
    logic [32:0] r;
    logic [31:0] a;
    logic [4:0]  rdn;
    logic        exp_we;
    a      = (ins[19:15] == 5'd0) ? 32'h0 : gold[ins[19:15]];
    r      = ref_op(ins, a);
    rdn    = ins[11:7];
    exp_we = r[32] && (rdn != 5'd0);
    check("wb_done", 32'(bus.done), 32'd1);
    check("wb_illegal", 32'(bus.illegal), 32'(!r[32]));
    check("wb_we", 32'(bus.we), 32'(exp_we));
    if (r[32]) begin
      check("wb_rd", 32'(bus.rd), 32'(rdn));
      check("wb_rd_value", bus.rd_value, r[31:0]);
    end
    if (exp_we) gold[rdn] = r[31:0];
  endtask

  task automatic run_instr(input logic [31:0] ins);
    logic [4:0] rdn;
    rdn = ins[11:7];
    check("acc_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    tick();
    bus.in_valid = 1'b0;
    check("ex_ready", 32'(bus.in_ready), 32'd0);
    check("ex_we", 32'(bus.we), 32'd0);
    check("ex_done", 32'(bus.done), 32'd0);
    check("ex_rs1", 32'(bus.rs1), 32'(ins[19:15]));
    tick();
    wb_check(ins);
    tick();
    check("idle_ready", 32'(bus.in_ready), 32'd1);
    check("idle_we", 32'(bus.we), 32'd0);
    check("idle_done", 32'(bus.done), 32'd0);
    check("idle_rs1", 32'(bus.rs1), 32'd0);
    if (rdn != 5'd0) check("rf_content", regs[rdn], gold[rdn]);
  endtask

  initial begin
    logic [31:0] ia;
    logic [31:0] ib;
    logic [31:0] old4;
    int          pat [6];
    int          n_acc;
    total         = 0;
    bad           = 0;
    poke_en       = 1'b0;
    poke_addr     = '0;
    poke_data     = '0;
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = enc_i(12'h001, 3, 0, 4);
    tick();
    tick();
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    check("rst_rs1", 32'(bus.rs1), 32'd0);
    check("rst_rd", 32'(bus.rd), 32'd0);
    check("rst_rd_value", bus.rd_value, 32'd0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Register file image; x0 deliberately returns garbage
    set_reg(0, 32'hDEAD_BEEF);
    for (int i = 1; i < 8; i++) set_reg(i, $urandom);
    set_reg(1, 32'h1234_5678);

    run_instr(32'h0F00_F293);
    check("andi_lit", bus.rd_value, 32'h0000_0070);
    run_instr(32'hFFF0_0193);
    check("addi_x0_lit", bus.rd_value, 32'hFFFF_FFFF);

    set_reg(1, 32'h8000_0000);
    run_instr(enc_i(12'h404, 1, 5, 2));
    check("srai_lit", bus.rd_value, 32'hF800_0000);
    run_instr(enc_i(12'h004, 1, 5, 2));
    check("srli_lit", bus.rd_value, 32'h0800_0000);
    run_instr(enc_i(12'hFFF, 1, 3, 2));
    check("sltiu_lit", bus.rd_value, 32'd1);
    run_instr(enc_i(12'h000, 1, 2, 2));
    check("slti_lit", bus.rd_value, 32'd1);

    run_instr(enc_i(12'h005, 1, 0, 0));
    run_instr(32'h0000_0033);
    run_instr(enc_i({7'h20, 5'd3}, 1, 1, 2));
    run_instr(enc_i({7'h10, 5'd3}, 1, 5, 2));

    // Dependent pair with in_valid held high for six cycles
    ia  = enc_i(12'h010, 1, 0, 6);
    ib  = enc_i(12'h5A5, 6, 4, 7);
    pat = '{1, 0, 0, 1, 0, 0};
    n_acc = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = ia;
    for (int i = 0; i < 6; i++) begin
      check("b2b_ready", 32'(bus.in_ready), 32'(pat[i]));
      if (i == 2) wb_check(ia);
      if (i == 5) wb_check(ib);
      if (bus.in_ready === 1'b1 && n_acc == 0) begin
        n_acc = 1;
        tick();
        bus.in_instr = ib;
      end else begin
        tick();
      end
    end
    bus.in_valid = 1'b0;
    check("b2b_end_ready", 32'(bus.in_ready), 32'd1);
    check("b2b_rf_x7", regs[7], gold[7]);

    // Reset during EXEC of ORI x4,x1,0x7FF
    old4 = gold[4];
    bus.in_valid = 1'b1;
    bus.in_instr = enc_i(12'h7FF, 1, 6, 4);
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rexec_we", 32'(bus.we), 32'd0);
    check("rexec_done", 32'(bus.done), 32'd0);
    check("rexec_illegal", 32'(bus.illegal), 32'd0);
    check("rexec_ready", 32'(bus.in_ready), 32'd1);
    check("rexec_rs1", 32'(bus.rs1), 32'd0);
    check("rexec_rd", 32'(bus.rd), 32'd0);
    check("rexec_rd_value", bus.rd_value, 32'd0);
    tick();
    check("rexec_we_after", 32'(bus.we), 32'd0);
    check("rexec_rf_x4", regs[4], old4);

    // Random OP-IMM traffic, occasionally malformed
    for (int n = 0; n < 40; n++) begin
      logic [11:0] imm12;
      logic [31:0] ins;
      int          f3;
      int          sel;
      f3    = int'($urandom_range(0, 7));
      imm12 = 12'($urandom);
      if (f3 == 1 || f3 == 5) begin
        sel = int'($urandom_range(0, 3));
        if (sel == 0)      imm12[11:5] = 7'h00;
        else if (sel == 1) imm12[11:5] = 7'h20;
        else if (sel == 2) imm12[11:5] = 7'h00;
      end
      ins = enc_i(imm12, int'($urandom_range(0, 7)), f3, int'($urandom_range(0, 7)));
      if ($urandom_range(0, 7) == 0) ins[6:0] = 7'($urandom);
      run_instr(ins);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
